// File: rtl/multu_unit_pkg.sv
// Shared MULTU definitions: funct codes seen by the decoder and the multiplier state encoding.
package multu_unit_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multu_unit.sv
// Sequential shift-add unsigned multiplier owning the HI/LO registers.
// Optional macro MULTU_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module multu_unit
  import multu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_e         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mplier_next;
  logic               w_last;

  // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_next = r_mplier >> 1;
`ifdef MULTU_EARLY_TERM_EN
    w_last        = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
    w_last        = (r_cnt == CW'(1));
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= MUL_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE, MUL_DONE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_mcand  <= {{WIDTH{1'b0}}, op_a};
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_state  <= MUL_BUSY;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= MUL_IDLE;
          end
        end
        MUL_BUSY: begin
          if (flush) begin
            // Squashed multiply: drop the result and leave HI/LO untouched.
            r_state <= MUL_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last) begin
              {r_hi, r_lo} <= w_acc_next;
              r_state      <= MUL_DONE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= MUL_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit: vector table, random operands and multi-cycle corner sequences.
module tb_multu_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks   = 0;
  int failures = 0;

  multu_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .flush(flush),
    .op_a (op_a),
    .op_b (op_b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Number of BUSY cycles before the result appears.
  function automatic int model_lat(input logic [WIDTH-1:0] b);
`ifdef MULTU_EARLY_TERM_EN
    if (b == '0) return 1;
    return $clog2(64'(b) + 64'd1);
`else
    return WIDTH;
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents operands with start for exactly one rising edge; returns #1 after that edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Follows one multiply through BUSY. start_at/flush_at (1-based BUSY cycle, 0 = never)
  // inject a stray start or a flush. Returns #1 after the edge that ended BUSY.
  task automatic track(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int start_at, input int flush_at);
    logic [WIDTH-1:0] prev_hi = hi;
    logic [WIDTH-1:0] prev_lo = lo;
    int n = 0;
    bit held = 1'b1;
    bit flushed = 1'b0;
    while (busy && n < WIDTH + 4) begin
      n++;
      if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
      if (n == start_at) begin
        op_a = 2; op_b = 2; start = 1'b1;
      end
      if (n == flush_at) begin
        flush = 1'b1; flushed = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
    end
    check({tag, " hold_during_busy"}, 64'(held), 64'd1);
    if (flushed) begin
      check({tag, " flush_busy"}, 64'(busy), 64'd0);
      check({tag, " flush_done"}, 64'(done), 64'd0);
      check({tag, " flush_hilo"}, {hi, lo}, {prev_hi, prev_lo});
    end else begin
      check({tag, " busy_cycles"}, 64'(n), 64'(model_lat(b)));
      check({tag, " done_pulse"}, 64'(done), 64'd1);
      check({tag, " hilo"}, {hi, lo}, model_mul(a, b));
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (busy || done) seen++;
    end
    check({tag, " quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{32'd3, 32'd5, 64'd15};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000};
    vecs[3] = '{32'd123, 32'd0, 64'd0};
    vecs[4] = '{32'd0, 32'hDEAD_BEEF, 64'd0};
    vecs[5] = '{32'h8000_0000, 32'd1, 64'h0000_0000_8000_0000};
    for (int i = 6; i < 10; i++) begin
      ra = $urandom;
      rb = (i == 9) ? 32'($urandom_range(1, 255)) : 32'($urandom);
      vecs[i] = '{ra, rb, model_mul(ra, rb)};
    end

    // Reset state
    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b1;
    step();

    // Basic 3*5
    issue(3, 5);
    track("basic", 3, 5, 0, 0);
    step();
    check("basic done_single", 64'(done), 64'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b);
      track($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0, 0);
      check($sformatf("vec%0d table", i), {hi, lo}, vecs[i].exp);
      step();
      check($sformatf("vec%0d done_clear", i), 64'(done), 64'd0);
    end

    // Stray start during BUSY is ignored: same result, no second completion
    lat = model_lat(5);
    issue(3, 5);
    track("ign", 3, 5, (lat > 10) ? 10 : 1, 0);
    quiet("ign", WIDTH + 8);
    check("ign lo", 64'(lo), 64'd15);

    // Start in the DONE cycle is accepted back-to-back
    issue(3, 5);
    track("b2b_first", 3, 5, 0, 0);
    issue(2, 2);
    check("b2b busy", 64'(busy), 64'd1);
    track("b2b_second", 2, 2, 0, 0);
    step();

    // Flush mid-BUSY leaves prior 0/15
    issue(3, 5);
    track("pre_flush", 3, 5, 0, 0);
    step();
    lat = model_lat(7);
    issue(6, 7);
    track("flush_mid", 6, 7, 0, (lat > 20) ? 20 : lat - 1);
    check("flush_mid prior", {hi, lo}, 64'd15);
    quiet("flush_mid", 8);

    // Flush coinciding with the completion edge
    issue(6, 7);
    track("flush_end", 6, 7, 0, lat);
    check("flush_end prior", {hi, lo}, 64'd15);
    quiet("flush_end", 4);

    // Flush together with start in IDLE: start dropped
    @(negedge clk);
    op_a = 6; op_b = 7; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-BUSY
    issue(7, 9);
    step(); step(); step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst done", 64'(done), 64'd0);
    check("arst hilo", {hi, lo}, 64'd0);
    step();
    @(negedge clk); rst = 1'b1;
    step();
    check("arst idle", 64'(busy | done), 64'd0);
    issue(7, 9);
    track("after_rst", 7, 9, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
